// File: rtl/pic_prog_loader.sv
// -----------------------------------------------------------------------------
// pic_prog_loader
//
// Serial in-system loader for a small core's program memory. A host opens a
// session by raising prog_en, streams DATA_W-bit instruction words MSB first
// on sdata/svalid, and closes it by lowering prog_en. Each complete word is
// written to consecutive addresses starting at 0. The memory doubles as the
// core's program ROM: Data is a combinational read of mem[Addr].
//
// Ports
//   clock       single clock, rising edge
//   reset       asynchronous, active-low reset (memory contents survive it)
//   prog_en     host session request (level)
//   sdata       serial instruction bit, MSB first
//   svalid      sdata valid this cycle
//   Addr        core fetch address
//   Data        instruction at Addr (combinational)
//   core_hold   hold the core in reset while a session is active
//   prog_busy   session active
//   prog_done   one-cycle pulse when a session completes without error
//   prog_err    sticky: session ended with a partial word
//   word_count  words written in the current or last session
// -----------------------------------------------------------------------------
module pic_prog_loader #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 12
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              prog_en,
   input  logic              sdata,
   input  logic              svalid,
   input  logic [ADDR_W-1:0] Addr,
   output logic [DATA_W-1:0] Data,
   output logic              core_hold,
   output logic              prog_busy,
   output logic              prog_done,
   output logic              prog_err,
   output logic [ADDR_W:0]   word_count
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int BIT_W = $clog2(DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DATA_W-1:0]   shreg_q, shreg_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W:0]     word_count_q, word_count_d;
   logic                err_q, err_d;
   logic                armed_q, armed_d;
   logic                busy_q;
   logic                done_q;
   logic                mem_we;

   logic [DATA_W-1:0]   mem [DEPTH];

   // -------------------------------------------------------------------------
   // Next-state and datapath decode
   // -------------------------------------------------------------------------
   // NOTE: every signal driven here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shreg_d      = shreg_q;
      addr_d       = addr_q;
      word_count_d = word_count_q;
      err_d        = err_q;
      armed_d      = armed_q;
      mem_we       = 1'b0;

      unique case (state_q)
         IDLE: begin
            // armed_q records that prog_en has been seen low in IDLE, so a
            // level held high across a finished session cannot re-trigger.
            if (!prog_en) begin
               armed_d = 1'b1;
            end else if (armed_q) begin
               state_d      = SHIFT;
               bit_cnt_d    = '0;
               addr_d       = '0;
               word_count_d = '0;
               err_d        = 1'b0;
               armed_d      = 1'b0;
            end
         end

         SHIFT: begin
            // Session end takes priority over a bit arriving the same cycle.
            if (!prog_en) begin
               state_d   = DONE;
               err_d     = (bit_cnt_q != '0);
               bit_cnt_d = '0;
            end else if (svalid) begin
               shreg_d = {shreg_q[DATA_W-2:0], sdata};
               if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = WRITE;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end

         WRITE: begin
            // svalid is not looked at here; the host leaves a gap cycle.
            mem_we       = 1'b1;
            addr_d       = addr_q + ADDR_W'(1);
            word_count_d = word_count_q + (ADDR_W + 1)'(1);
            if ((&addr_q) || !prog_en) begin
               state_d = DONE;
            end else begin
               state_d = SHIFT;
            end
         end

         DONE: begin
            state_d = IDLE;
            armed_d = 1'b0;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Control and status registers
   // -------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shreg_q      <= '0;
         addr_q       <= '0;
         word_count_q <= '0;
         err_q        <= 1'b0;
         armed_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shreg_q      <= shreg_d;
         addr_q       <= addr_d;
         word_count_q <= word_count_d;
         err_q        <= err_d;
         armed_q      <= armed_d;
         // Status flags are registered from the next state so they carry no
         // combinational path from prog_en.
         busy_q       <= (state_d != IDLE);
         done_q       <= (state_d == DONE) && !err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Program memory
   // -------------------------------------------------------------------------
   // NOTE: the memory has no reset; a program loaded before a reset must
   // survive it, and an async reset on the array would prevent RAM mapping.
   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[addr_q] <= shreg_q;
      end
   end

   assign Data       = mem[Addr];
   assign core_hold  = busy_q;
   assign prog_busy  = busy_q;
   assign prog_done  = done_q;
   assign prog_err   = err_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_pic_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_pic_prog_loader
//
// Directed bench for pic_prog_loader: a short three-word load, the same load
// with gapped svalid ending inside the WRITE cycle, an aborted partial word,
// a reset in the middle of a word, and a full 512-word load followed by a
// held prog_en and a fresh empty session.
// -----------------------------------------------------------------------------
module tb_pic_prog_loader;

   localparam int ADDR_W = 9;
   localparam int DATA_W = 12;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clock = 1'b0;
   logic              reset;
   logic              prog_en;
   logic              sdata;
   logic              svalid;
   logic [ADDR_W-1:0] Addr;
   logic [DATA_W-1:0] Data;
   logic              core_hold;
   logic              prog_busy;
   logic              prog_done;
   logic              prog_err;
   logic [ADDR_W:0]   word_count;

   int n_cmp    = 0;
   int n_bad    = 0;
   int done_cnt = 0;

   logic [DATA_W-1:0] words3 [3];

   pic_prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock      (clock),
      .reset      (reset),
      .prog_en    (prog_en),
      .sdata      (sdata),
      .svalid     (svalid),
      .Addr       (Addr),
      .Data       (Data),
      .core_hold  (core_hold),
      .prog_busy  (prog_busy),
      .prog_done  (prog_done),
      .prog_err   (prog_err),
      .word_count (word_count)
   );

   always #5 clock = ~clock;

   // prog_done pulses are tallied mid-cycle, away from the active edge.
   always @(negedge clock) begin
      if (prog_done === 1'b1) done_cnt++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before the end of the run");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Returns with the DUT in SHIFT, session counters cleared.
   task automatic start_session();
      prog_en = 1'b0;
      svalid  = 1'b0;
      tick();
      tick();
      prog_en = 1'b1;
      tick();
   endtask

   // Twelve valid bits, then the WRITE cycle. During WRITE svalid is driven
   // high with a 1 to show the DUT ignores it. With gap set, an idle cycle
   // separates consecutive valid bits.
   task automatic send_word(input logic [DATA_W-1:0] w, input bit gap, input bit drop_in_write);
      for (int i = DATA_W - 1; i >= 0; i--) begin
         sdata  = w[i];
         svalid = 1'b1;
         tick();
         if (gap && i != 0) begin
            svalid = 1'b0;
            sdata  = 1'b0;
            tick();
         end
      end
      svalid = 1'b1;
      sdata  = 1'b1;
      if (drop_in_write) prog_en = 1'b0;
      tick();
      svalid = 1'b0;
      sdata  = 1'b0;
   endtask

   task automatic send_bits(input logic [DATA_W-1:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         sdata  = w[DATA_W-1-i];
         svalid = 1'b1;
         tick();
      end
      svalid = 1'b0;
      sdata  = 1'b0;
   endtask

   task automatic sweep3(input string tag);
      for (int a = 0; a < 3; a++) begin
         Addr = ADDR_W'(a);
         #1;
         check($sformatf("%s_data%0d", tag, a), 32'(Data), 32'(words3[a]));
      end
   endtask

   initial begin
      words3[0] = 12'hA5C;
      words3[1] = 12'h001;
      words3[2] = 12'hFFF;

      reset   = 1'b0;
      prog_en = 1'b0;
      sdata   = 1'b0;
      svalid  = 1'b0;
      Addr    = '0;
      #12;
      check("rst_busy", 32'(prog_busy), 32'd0);
      check("rst_hold", 32'(core_hold), 32'd0);
      check("rst_done", 32'(prog_done), 32'd0);
      check("rst_err",  32'(prog_err),  32'd0);
      check("rst_wc",   32'(word_count), 32'd0);
      reset = 1'b1;

      // ---- three-word load, normal end ----------------------------------
      start_session();
      check("s1_busy", 32'(prog_busy), 32'd1);
      check("s1_hold", 32'(core_hold), 32'd1);
      send_word(words3[0], 1'b0, 1'b0);
      check("s1_wc1", 32'(word_count), 32'd1);
      Addr = '0;
      #1;
      check("s1_data_after_write", 32'(Data), 32'hA5C);
      send_word(words3[1], 1'b0, 1'b0);
      send_word(words3[2], 1'b0, 1'b0);
      check("s1_wc3", 32'(word_count), 32'd3);
      prog_en = 1'b0;
      tick();
      check("s1_done_pulse", 32'(prog_done), 32'd1);
      check("s1_err", 32'(prog_err), 32'd0);
      check("s1_busy_in_done", 32'(prog_busy), 32'd1);
      tick();
      check("s1_done_low", 32'(prog_done), 32'd0);
      check("s1_idle_hold", 32'(core_hold), 32'd0);
      check("s1_done_cnt", 32'(done_cnt), 32'd1);
      sweep3("s1");

      // ---- gapped svalid, prog_en dropped inside the last WRITE ---------
      start_session();
      check("s2_wc_cleared", 32'(word_count), 32'd0);
      send_word(words3[0], 1'b1, 1'b0);
      send_word(words3[1], 1'b1, 1'b0);
      send_word(words3[2], 1'b1, 1'b1);
      check("s2_done_pulse", 32'(prog_done), 32'd1);
      check("s2_wc3", 32'(word_count), 32'd3);
      check("s2_err", 32'(prog_err), 32'd0);
      tick();
      check("s2_done_cnt", 32'(done_cnt), 32'd2);
      sweep3("s2");

      // ---- abort after 5 bits of the second word ------------------------
      start_session();
      send_word(12'h123, 1'b0, 1'b0);
      send_bits(12'hABC, 5);
      prog_en = 1'b0;
      tick();
      check("s3_err", 32'(prog_err), 32'd1);
      check("s3_no_done", 32'(prog_done), 32'd0);
      check("s3_wc1", 32'(word_count), 32'd1);
      tick();
      check("s3_err_sticky", 32'(prog_err), 32'd1);
      check("s3_idle_busy", 32'(prog_busy), 32'd0);
      check("s3_done_cnt", 32'(done_cnt), 32'd2);
      Addr = ADDR_W'(0);
      #1;
      check("s3_mem0", 32'(Data), 32'h123);
      Addr = ADDR_W'(1);
      #1;
      check("s3_mem1_kept", 32'(Data), 32'h001);

      // ---- reset in the middle of the second word -----------------------
      start_session();
      check("s4_err_cleared", 32'(prog_err), 32'd0);
      send_word(12'h456, 1'b0, 1'b0);
      check("s4_wc1", 32'(word_count), 32'd1);
      send_bits(12'h789, 5);
      #2;
      reset = 1'b0;
      #1;
      check("s4_rst_busy", 32'(prog_busy), 32'd0);
      check("s4_rst_hold", 32'(core_hold), 32'd0);
      check("s4_rst_wc",   32'(word_count), 32'd0);
      check("s4_rst_done", 32'(prog_done), 32'd0);
      check("s4_rst_err",  32'(prog_err),  32'd0);
      prog_en = 1'b0;
      #3;
      reset = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      Addr = ADDR_W'(0);
      #1;
      check("s4_mem0_kept", 32'(Data), 32'h456);
      Addr = ADDR_W'(1);
      #1;
      check("s4_mem1_kept", 32'(Data), 32'h001);
      check("s4_done_cnt", 32'(done_cnt), 32'd2);

      // ---- full-memory load with prog_en held high ----------------------
      start_session();
      for (int i = 0; i < DEPTH; i++) begin
         send_word(DATA_W'(i) ^ 12'h5A5, 1'b0, 1'b0);
      end
      check("s5_done_pulse", 32'(prog_done), 32'd1);
      check("s5_wc512", 32'(word_count), 32'd512);
      check("s5_busy_in_done", 32'(prog_busy), 32'd1);
      for (int i = 0; i < 6; i++) tick();
      check("s5_no_restart", 32'(prog_busy), 32'd0);
      check("s5_wc_held", 32'(word_count), 32'd512);
      check("s5_done_cnt", 32'(done_cnt), 32'd3);

      // prog_en toggled: a new, empty session ends normally.
      start_session();
      check("s6_busy", 32'(prog_busy), 32'd1);
      check("s6_wc0", 32'(word_count), 32'd0);
      prog_en = 1'b0;
      tick();
      check("s6_done_pulse", 32'(prog_done), 32'd1);
      check("s6_err", 32'(prog_err), 32'd0);
      tick();
      check("s6_done_cnt", 32'(done_cnt), 32'd4);

      for (int a = 0; a < DEPTH; a++) begin
         Addr = ADDR_W'(a);
         #1;
         check($sformatf("s5_mem%0d", a), 32'(Data), 32'(DATA_W'(a) ^ 12'h5A5));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
